simple_ntt_seq: RTL and testbench
=================================

SIMPLE_NTT_SEQ -- requirements
Module: simple_ntt_seq

Interface
REQ-001 Parameter data_width, default 32: width of every coefficient and result word.
REQ-002 Parameter n, default 4: transform length; fixed at 4, and other values are unsupported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  data_width  input coefficient word.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 core_buf0..core_buf3  output  data_width each  coefficient buffer driven to the NTT datapath core.
REQ-009 core_index  output  2  output-point index driven to the core.
REQ-010 core_result  input  data_width  combinational core result for the current core_buf*/core_index.
REQ-011 out_data  output  data_width  transformed coefficient.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_last  output  1  high with out_valid on the final (index 3) result of a transform.
REQ-015 busy  output  1  high whenever state is not LOAD.

Function
REQ-016 The FSM SHALL have exactly three states: LOAD, CALC and SEND.
REQ-017 A word SHALL be accepted on in_valid & in_ready; in_ready SHALL be 1 only in LOAD.
REQ-018 In LOAD, a 2-bit load counter k SHALL select the buffer: an accepted word writes buf[k] and k increments.
REQ-019 Acceptance of the 4th word (k==3) SHALL clear k, set idx=0 and move the FSM to CALC on the next cycle.
REQ-020 core_buf0..3 SHALL be driven from buf[0..3]; buffers SHALL hold unchanged outside LOAD writes.
REQ-021 core_index SHALL equal the 2-bit output counter idx.
REQ-022 In CALC (one cycle), out_data SHALL register core_result, and the FSM SHALL move to SEND.
REQ-023 In SEND, out_valid SHALL be 1, and out_data and out_last SHALL hold stable until out_valid & out_ready.
REQ-024 out_last SHALL be 1 in SEND iff idx==3.
REQ-025 On a SEND handshake with idx<3, idx SHALL increment and the FSM SHALL go to CALC.
REQ-026 On a SEND handshake with idx==3, idx SHALL clear and the FSM SHALL go to LOAD.
REQ-027 Latency: the first out_valid SHALL occur 2 cycles after the 4th input handshake.
REQ-028 With out_ready held high, results SHALL issue every 2 cycles: 4 results in 8 cycles.
REQ-029 in_valid outside LOAD SHALL be ignored: no buffer write and no counter change.
REQ-030 out_ready outside SEND SHALL have no effect.
REQ-031 The block SHALL perform no arithmetic on data; all modular arithmetic resides in the core.
REQ-032 Counters SHALL wrap modulo 4 with no overflow state.

Reset
REQ-033 While reset==0, state SHALL be LOAD, and k, idx, buf[0..3] and out_data SHALL be 0.
REQ-034 While reset==0, out_valid and out_last SHALL be 0; in_ready SHALL be 1 once reset deasserts.
REQ-035 Reset mid-load or mid-send SHALL abort the transform immediately.
REQ-036 After reset deasserts, the next accepted word SHALL be written to buf[0].

Verification
REQ-037 The bench SHALL connect the team's 4-point core: result = (sum over j of buf[j]*tw[(index+j) mod 4]) mod 12289, tw={1,1479,12288,10810}.
REQ-038 Load 1,0,0,0, out_ready=1 -> outputs 1,1479,12288,10810; out_last only on 10810; first out_valid 2 cycles after 4th input.
REQ-039 Load 1,1,1,1 -> outputs 0,0,0,0; busy falls the cycle after the 4th output handshake.
REQ-040 Load 0,1,0,0 with out_ready low for 5 cycles -> out_valid held, out_data=1479 stable; on release, outputs 1479,12288,10810,1 in order.
REQ-041 Drive in_valid=1 continuously during CALC/SEND with junk data -> in_ready=0, buffers unchanged, results unaffected.
REQ-042 Assert reset after the 2nd result handshake -> out_valid=0 immediately; next load of 1,0,0,0 yields 1,1479,12288,10810.

Source files
------------

// File: rtl/simple_ntt_seq.sv
// 4-point NTT sequencer: loads four coefficients, steps an external
// core through the four output points and streams the results out.
module simple_ntt_seq #(
  parameter int data_width = 32,
  parameter int n          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_width-1:0] core_buf0,
  output logic [data_width-1:0] core_buf1,
  output logic [data_width-1:0] core_buf2,
  output logic [data_width-1:0] core_buf3,
  output logic [1:0]            core_index,
  input  logic [data_width-1:0] core_result,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                state;
  logic [1:0]            k;
  logic [1:0]            idx;
  logic [data_width-1:0] coef [n];

  // Handshake flags decode straight from the state register.
  assign in_ready   = (state == LOAD);
  assign out_valid  = (state == SEND);
  assign out_last   = (state == SEND) && (idx == 2'd3);
  assign busy       = (state != LOAD);

  assign core_buf0  = coef[0];
  assign core_buf1  = coef[1];
  assign core_buf2  = coef[2];
  assign core_buf3  = coef[3];
  assign core_index = idx;

  // Sequencer: fill buffers, then alternate CALC/SEND per output point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      k        <= 2'd0;
      idx      <= 2'd0;
      out_data <= '0;
      for (int i = 0; i < n; i++) begin
        coef[i] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            coef[k] <= in_data;
            if (k == 2'd3) begin
              k     <= 2'd0;
              idx   <= 2'd0;
              state <= CALC;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        CALC: begin
          out_data <= core_result;
          state    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              state <= LOAD;
            end else begin
              idx   <= idx + 2'd1;
              state <= CALC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_ntt_seq.sv
// Bench for simple_ntt_seq with a behavioural 4-point core
// (modulus 12289) and directed plus randomized transforms.
module tb_simple_ntt_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] core_buf0, core_buf1, core_buf2, core_buf3;
  logic [1:0]  core_index;
  logic [31:0] core_result;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int cmp  = 0;
  int errs = 0;

  simple_ntt_seq #(.data_width(32), .n(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .core_buf0   (core_buf0),
    .core_buf1   (core_buf1),
    .core_buf2   (core_buf2),
    .core_buf3   (core_buf3),
    .core_index  (core_index),
    .core_result (core_result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic longint tw_of(input int i);
    case (i % 4)
      0:       return 1;
      1:       return 1479;
      2:       return 12288;
      default: return 10810;
    endcase
  endfunction

  // Reference: output point i of the 4-point transform of c0..c3.
  function automatic logic [31:0] ref_pt(input logic [31:0] c0,
                                         input logic [31:0] c1,
                                         input logic [31:0] c2,
                                         input logic [31:0] c3,
                                         input int i);
    longint s;
    s = longint'(c0) * tw_of(i)
      + longint'(c1) * tw_of(i + 1)
      + longint'(c2) * tw_of(i + 2)
      + longint'(c3) * tw_of(i + 3);
    return 32'(s % 12289);
  endfunction

  // Behavioural core attached to the DUT.
  always_comb begin
    core_result = ref_pt(core_buf0, core_buf1, core_buf2, core_buf3,
                         int'(core_index));
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Load four words; ends at the negedge following the 4th handshake
  // (CALC), then checks the 2-cycle latency and ends in SEND.
  task automatic load4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d,
                       input bit junk);
    logic [31:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      in_data  = w[i];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = junk;
    in_data  = $urandom;
    chk("lat_calc_valid", {31'd0, out_valid}, 32'd0);
    chk("busy_calc", {31'd0, busy}, 32'd1);
    @(negedge clk);
    in_data = $urandom;
    chk("lat_send_valid", {31'd0, out_valid}, 32'd1);
    chk("buf0", core_buf0, a);
    chk("buf1", core_buf1, b);
    chk("buf2", core_buf2, c);
    chk("buf3", core_buf3, d);
  endtask

  // Collect four results with out_ready high, checking data, last
  // flag, issue rate and that busy drops after the final handshake.
  task automatic collect(input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3,
                         input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
    logic [31:0] e [4];
    int wt;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wt = 0;
      while (!out_valid && wt < 20) begin
        @(negedge clk);
        in_data = $urandom;
        wt++;
      end
      chk("gap", 32'(wt), (i == 0) ? 32'd0 : 32'd1);
      chk("out_data", out_data, e[i]);
      chk("out_last", {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("valid_done", {31'd0, out_valid}, 32'd0);
    chk("hold_buf0", core_buf0, b0);
    chk("hold_buf1", core_buf1, b1);
    chk("hold_buf2", core_buf2, b2);
    chk("hold_buf3", core_buf3, b3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r [4];
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_buf0", core_buf0, 32'd0);
    chk("rst_buf3", core_buf3, 32'd0);
    chk("rst_index", {30'd0, core_index}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Impulse at coefficient 0.
    out_ready = 1'b1;
    load4(1, 0, 0, 0, 1'b0);
    collect(1, 1479, 12288, 10810, 1, 0, 0, 0);

    // All-ones sums to 2*12289.
    load4(1, 1, 1, 1, 1'b0);
    collect(0, 0, 0, 0, 1, 1, 1, 1);

    // Back-pressure on the first result.
    out_ready = 1'b0;
    load4(0, 1, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'd1479);
      chk("stall_last", {31'd0, out_last}, 32'd0);
    end
    collect(1479, 12288, 10810, 1, 0, 1, 0, 0);

    // Junk inputs while busy must be ignored.
    load4(5, 7, 11, 13, 1'b1);
    collect(ref_pt(5, 7, 11, 13, 0), ref_pt(5, 7, 11, 13, 1),
            ref_pt(5, 7, 11, 13, 2), ref_pt(5, 7, 11, 13, 3),
            5, 7, 11, 13);

    // Reset after the second result handshake.
    out_ready = 1'b1;
    load4(1, 0, 0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_data", out_data, 32'd1479);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_buf0", core_buf0, 32'd0);
    chk("abort_data", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    load4(1, 0, 0, 0, 1'b0);
    collect(1, 1479, 12288, 10810, 1, 0, 0, 0);

    // Randomized transforms.
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 4; j++) r[j] = $urandom_range(0, 12288);
      load4(r[0], r[1], r[2], r[3], t[0]);
      collect(ref_pt(r[0], r[1], r[2], r[3], 0),
              ref_pt(r[0], r[1], r[2], r[3], 1),
              ref_pt(r[0], r[1], r[2], r[3], 2),
              ref_pt(r[0], r[1], r[2], r[3], 3),
              r[0], r[1], r[2], r[3]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
